// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared constants for the multi-cycle MIPS control path.
//   Contents:
//     OP_*          6-bit primary opcodes recognised by the controller
//     ALUOP_*       2-bit ALUOp encodings consumed by the ALU control decoder
//     ctrl_state_t  state encoding of the main control FSM
//     is_supported  true when an opcode is one the controller can sequence
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Codes 12..15 are unused; the controller treats them as a recovery path.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } ctrl_state_t;

  function automatic logic is_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: is_supported = 1'b1;
      default:                                      is_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM of the multi-cycle MIPS datapath. Sequences fetch,
//   decode, execute, memory and writeback cycles for R-type, LW, SW, BEQ,
//   J and ADDI, stalling on the memory ready handshake.
//   Ports:
//     clk, rst_n     clock (rising edge), asynchronous active-low reset
//     opcode         IR[31:26], valid from DECODE onward
//     mem_ready      memory finished the current access this cycle
//     PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
//     PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst
//                    datapath selects and write enables
//     instr_done     pulse in the final cycle of each instruction
//     illegal_op     pulse in DECODE when the opcode is unsupported
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       instr_done,
  output logic       illegal_op
);

  ctrl_state_t state;
  ctrl_state_t next_state;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decoder
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_ADDI:      next_state = S_IEXEC;
          default:      next_state = S_FETCH;
        endcase
      end
      // Only LW and SW reach MEMADR, so anything other than LW is a store.
      S_MEMADR: next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  next_state = S_FETCH;
      S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   next_state = S_RWB;
      S_RWB:    next_state = S_FETCH;
      S_IEXEC:  next_state = S_IWB;
      S_IWB:    next_state = S_FETCH;
      S_BRANCH: next_state = S_FETCH;
      S_JUMP:   next_state = S_FETCH;
      default:  next_state = S_FETCH;
    endcase
  end

  // Output decoder. Mostly Moore; the fetch writes and the store commit
  // follow mem_ready so nothing is written until memory has responded.
  // During reset the register already reads FETCH, so only the write
  // enables and pulses need forcing low to keep the datapath untouched.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = ALUOP_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        illegal_op = !is_supported(opcode);
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        MemWrite   = mem_ready;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_RWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_IWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      default: begin
      end
    endcase
    if (!rst_n) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Self-checking bench for multicycle_ctrl. A per-instruction plan model
//   predicts every output on every cycle; directed instruction sequences
//   with hand-computed latencies and output literals pin the model.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'b000000;
  logic       mem_ready = 1'b1;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst, instr_done, illegal_op;

  typedef struct packed {
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic [1:0] PCSource;
    logic [1:0] ALUOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic       RegDst;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_out_t;

  // Instruction phases as seen by the programmer, not the RTL encoding
  localparam int PH_FETCH = 0, PH_DECODE = 1, PH_ADDR = 2, PH_RD = 3, PH_MWB = 4,
                 PH_WR = 5, PH_EXEC = 6, PH_RWB = 7, PH_IEX = 8, PH_IWB = 9,
                 PH_BR = 10, PH_JMP = 11;

  localparam logic [5:0] RTYPE = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000,
                         BAD = 6'b111111;

  int assertCount = 0;
  int failCount   = 0;
  ctrl_out_t trace[$];
  int phaseQ[$];

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  function automatic ctrl_out_t dutOut();
    ctrl_out_t o;
    o = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
         PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, instr_done, illegal_op};
    return o;
  endfunction

  function automatic logic knownOp(input logic [5:0] op);
    return (op == RTYPE) || (op == LW) || (op == SW) || (op == BEQ) ||
           (op == JMP) || (op == ADDI);
  endfunction

  // What the datapath must see in a given phase of an instruction
  function automatic ctrl_out_t modelOut(input int ph, input logic mr,
                                         input logic [5:0] op, input logic inReset);
    ctrl_out_t o;
    o = '0;
    case (ph)
      PH_FETCH:  begin o.MemRead = 1; o.ALUSrcB = 2'b01; o.IRWrite = mr; o.PCWrite = mr; end
      PH_DECODE: begin o.ALUSrcB = 2'b11; o.illegal_op = !knownOp(op); end
      PH_ADDR:   begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; end
      PH_RD:     begin o.MemRead = 1; o.IorD = 1; end
      PH_MWB:    begin o.RegWrite = 1; o.MemtoReg = 1; o.instr_done = 1; end
      PH_WR:     begin o.IorD = 1; o.MemWrite = mr; o.instr_done = mr; end
      PH_EXEC:   begin o.ALUSrcA = 1; o.ALUOp = 2'b10; end
      PH_RWB:    begin o.RegWrite = 1; o.RegDst = 1; o.instr_done = 1; end
      PH_IEX:    begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; end
      PH_IWB:    begin o.RegWrite = 1; o.instr_done = 1; end
      PH_BR:     begin o.ALUSrcA = 1; o.ALUOp = 2'b01; o.PCWriteCond = 1;
                       o.PCSource = 2'b01; o.instr_done = 1; end
      PH_JMP:    begin o.PCWrite = 1; o.PCSource = 2'b10; o.instr_done = 1; end
      default:   o = '0;
    endcase
    if (inReset) begin
      o.PCWrite = 0; o.PCWriteCond = 0; o.IRWrite = 0; o.MemWrite = 0;
      o.RegWrite = 0; o.instr_done = 0; o.illegal_op = 0;
    end
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model compare process: check every cycle, then advance the plan using
  // the inputs the next clock edge will see.
  always @(negedge clk) begin
    int front;
    if (!rst_n) begin
      phaseQ.delete();
      phaseQ.push_back(PH_FETCH);
      checkOutput("model_reset", dutOut(), modelOut(PH_FETCH, mem_ready, opcode, 1'b1));
    end else begin
      front = phaseQ[0];
      checkOutput($sformatf("model_ph%0d", front), dutOut(),
                  modelOut(front, mem_ready, opcode, 1'b0));
      if (!((front == PH_FETCH || front == PH_RD || front == PH_WR) && !mem_ready)) begin
        void'(phaseQ.pop_front());
        if (front == PH_FETCH) phaseQ.push_back(PH_DECODE);
        else if (front == PH_DECODE) begin
          case (opcode)
            LW:    begin phaseQ.push_back(PH_ADDR); phaseQ.push_back(PH_RD); phaseQ.push_back(PH_MWB); end
            SW:    begin phaseQ.push_back(PH_ADDR); phaseQ.push_back(PH_WR); end
            RTYPE: begin phaseQ.push_back(PH_EXEC); phaseQ.push_back(PH_RWB); end
            ADDI:  begin phaseQ.push_back(PH_IEX); phaseQ.push_back(PH_IWB); end
            BEQ:   phaseQ.push_back(PH_BR);
            JMP:   phaseQ.push_back(PH_JMP);
            default: ;
          endcase
        end
        if (phaseQ.size() == 0) phaseQ.push_back(PH_FETCH);
      end
    end
  end

  // Runs one instruction from FETCH entry. mem_ready is low on cycles
  // [waitAt, waitAt+waitLen); reset is asserted in cycle resetAt.
  // latency counts cycles up to and including instr_done/illegal_op.
  task automatic applyStimulus(input logic [5:0] op, input int waitAt, input int waitLen,
                               input int resetAt, output int latency);
    latency = -1;
    trace.delete();
    opcode = op;
    for (int c = 0; c < 40; c++) begin
      mem_ready = !(c >= waitAt && c < waitAt + waitLen);
      if (c == resetAt) rst_n = 1'b0;
      @(negedge clk);
      trace.push_back(dutOut());
      if (c == resetAt) break;
      if (instr_done || illegal_op) begin
        latency = c + 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int cnt;
    $display("[TB] starting multicycle_ctrl bench");

    // Reset held with mem_ready high: writes suppressed, fetch selects shown
    repeat (2) @(negedge clk);
    checkOutput("rst_PCWrite", PCWrite, 0);
    checkOutput("rst_IRWrite", IRWrite, 0);
    checkOutput("rst_MemRead", MemRead, 1);
    checkOutput("rst_ALUSrcB", ALUSrcB, 2'b01);
    checkOutput("rst_done", instr_done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // R-type
    applyStimulus(RTYPE, -1, 0, -1, lat);
    checkOutput("rtype_latency", lat, 4);
    checkOutput("rtype_fetch_IRWrite", trace[0].IRWrite, 1);
    checkOutput("rtype_exec_ALUOp", trace[2].ALUOp, 2'b10);
    checkOutput("rtype_rwb_RegWrite", trace[3].RegWrite, 1);
    checkOutput("rtype_rwb_RegDst", trace[3].RegDst, 1);

    // LW with two stall cycles in the memory read
    applyStimulus(LW, 3, 2, -1, lat);
    checkOutput("lw_latency", lat, 7);
    checkOutput("lw_stall_IorD", trace[4].IorD, 1);
    checkOutput("lw_stall_MemRead", trace[4].MemRead, 1);
    checkOutput("lw_wb_MemtoReg", trace[6].MemtoReg, 1);
    checkOutput("lw_wb_RegWrite", trace[6].RegWrite, 1);

    // SW, unstalled then with one memory stall
    applyStimulus(SW, -1, 0, -1, lat);
    checkOutput("sw_latency", lat, 4);
    applyStimulus(SW, 3, 1, -1, lat);
    checkOutput("sw_stall_latency", lat, 5);
    cnt = 0;
    foreach (trace[i]) cnt += trace[i].MemWrite;
    checkOutput("sw_MemWrite_cycles", cnt, 1);
    checkOutput("sw_MemWrite_wait", trace[3].MemWrite, 0);
    cnt = 0;
    foreach (trace[i]) cnt += trace[i].RegWrite;
    checkOutput("sw_RegWrite_cycles", cnt, 0);

    // BEQ then J
    applyStimulus(BEQ, -1, 0, -1, lat);
    checkOutput("beq_latency", lat, 3);
    checkOutput("beq_ALUOp", trace[2].ALUOp, 2'b01);
    checkOutput("beq_PCWriteCond", trace[2].PCWriteCond, 1);
    checkOutput("beq_PCSource", trace[2].PCSource, 2'b01);
    applyStimulus(JMP, -1, 0, -1, lat);
    checkOutput("j_latency", lat, 3);
    checkOutput("j_PCWrite", trace[2].PCWrite, 1);
    checkOutput("j_PCSource", trace[2].PCSource, 2'b10);

    // ADDI
    applyStimulus(ADDI, -1, 0, -1, lat);
    checkOutput("addi_latency", lat, 4);
    checkOutput("addi_iwb_RegWrite", trace[3].RegWrite, 1);
    checkOutput("addi_iwb_RegDst", trace[3].RegDst, 0);

    // R-type with a fetch stall: no instruction load until memory is ready
    applyStimulus(RTYPE, 0, 1, -1, lat);
    checkOutput("fstall_latency", lat, 5);
    checkOutput("fstall_IRWrite_wait", trace[0].IRWrite, 0);
    checkOutput("fstall_IRWrite_ready", trace[1].IRWrite, 1);

    // Unsupported opcode
    applyStimulus(BAD, -1, 0, -1, lat);
    checkOutput("illegal_latency", lat, 2);
    checkOutput("illegal_pulse", trace[1].illegal_op, 1);
    checkOutput("illegal_writes", {trace[1].PCWrite, trace[1].PCWriteCond, trace[1].IRWrite,
                                   trace[1].MemWrite, trace[1].RegWrite, trace[1].instr_done}, 0);
    applyStimulus(JMP, -1, 0, -1, lat);
    checkOutput("after_illegal_latency", lat, 3);

    // Reset during LW writeback aborts the instruction
    applyStimulus(LW, -1, 0, 4, lat);
    checkOutput("abort_RegWrite", trace[4].RegWrite, 0);
    checkOutput("abort_done", trace[4].instr_done, 0);
    checkOutput("abort_fetch_MemRead", trace[4].MemRead, 1);
    checkOutput("abort_fetch_IorD", trace[4].IorD, 0);
    rst_n = 1'b1;
    applyStimulus(RTYPE, -1, 0, -1, lat);
    checkOutput("recover_latency", lat, 4);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
